neuron_feeder: RTL and testbench

- Upstream sequencer for the single-neuron datapath (MAC -> bias adder -> activation, three register stages).
- Holds one input vector and one weight vector in small local register files. Latches a bias.
- On start, streams (x, w) pairs one per cycle into the neuron with framing strobes, then waits out the neuron pipeline and pulses done on the cycle the neuron's y is valid.

---
 rtl/neuron_feeder.sv | 172 +++++++++++++++++
 tb/tb_neuron_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_feeder.sv
// Sequencer that streams stored (x, w) pairs plus a bias into the single-neuron datapath.
// Optional NEURON_FEEDER_SKIP_ZERO_EN: skip pairs whose weight is zero.
module neuron_feeder #(
  parameter int N_INPUTS     = 3,
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              bias_we,
  input  logic [DATA_W-1:0] bias_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mac_clr,
  output logic              mac_valid,
  output logic              mac_last,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] w_out,
  output logic [DATA_W-1:0] bias_out
);

  localparam logic [4:0] NW = 5'(N_INPUTS);
  localparam logic [3:0] DL = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, STREAM, DRAIN, DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] in_f [N_INPUTS];
  logic [DATA_W-1:0] wt_f [N_INPUTS];
  logic [DATA_W-1:0] bias_q;

  logic [4:0] ptr, ptr_nx, cand, after;
  logic [3:0] cnt, cnt_nx;
  logic [N_INPUTS-1:0] elig;
  logic [DATA_W-1:0] x_sel, w_sel;

  logic busy_nx, done_nx, clr_nx, valid_nx, last_nx;
  logic [DATA_W-1:0] x_nx, w_nx, bias_nx;

  // Lowest eligible index at or above 'from'; NW when none remain.
  function automatic logic [4:0] find(
    input logic [N_INPUTS-1:0] m,
    input logic [4:0] from
  );
    find = NW;
    for (int i = N_INPUTS - 1; i >= 0; i--)
      if (m[i] && 5'(i) >= from) find = 5'(i);
  endfunction

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) begin
`ifdef NEURON_FEEDER_SKIP_ZERO_EN
      elig[i] = (wt_f[i] != '0);
`else
      elig[i] = 1'b1;
`endif
    end
  end

  // Next pair to issue and whether another follows it.
  always_comb begin
    cand  = (state == CLEAR) ? find(elig, 5'd0)
                             : find(elig, ptr + 5'd1);
    after = find(elig, cand + 5'd1);
    x_sel = '0;
    w_sel = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (cand == 5'(i)) begin
        x_sel = in_f[i];
        w_sel = wt_f[i];
      end
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    clr_nx   = 1'b0;
    valid_nx = 1'b0;
    last_nx  = 1'b0;
    x_nx     = '0;
    w_nx     = '0;
    bias_nx  = bias_out;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = CLEAR;
          clr_nx   = 1'b1;
          bias_nx  = bias_we ? bias_in : bias_q;
        end
      end
      CLEAR, STREAM: begin
        if (cand == NW) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          state_nx = STREAM;
          ptr_nx   = cand;
          valid_nx = 1'b1;
          last_nx  = (after == NW);
          x_nx     = x_sel;
          w_nx     = w_sel;
        end
      end
      DRAIN: begin
        if (cnt == DL) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_clr   <= 1'b0;
      mac_valid <= 1'b0;
      mac_last  <= 1'b0;
      x_out     <= '0;
      w_out     <= '0;
      bias_out  <= '0;
      bias_q    <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        in_f[i] <= '0;
        wt_f[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      cnt       <= cnt_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      mac_clr   <= clr_nx;
      mac_valid <= valid_nx;
      mac_last  <= last_nx;
      x_out     <= x_nx;
      w_out     <= w_nx;
      bias_out  <= bias_nx;
      // Configuration is frozen outside IDLE.
      if (state == IDLE) begin
        if (bias_we) bias_q <= bias_in;
        for (int i = 0; i < N_INPUTS; i++) begin
          if (cfg_we && cfg_addr == 4'(i)) begin
            if (cfg_sel) wt_f[i] <= cfg_data;
            else         in_f[i] <= cfg_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Randomized self-checking bench for neuron_feeder against a pair-list model.
// Build with NEURON_FEEDER_SKIP_ZERO_EN to cover the zero-weight skip variant.
module tb_neuron_feeder;

  localparam int N = 3;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic cfg_sel = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic bias_we = 1'b0;
  logic [7:0] bias_in = '0;
  logic start = 1'b0;
  logic busy, done, mac_clr, mac_valid, mac_last;
  logic [7:0] x_out, w_out, bias_out;

  int total = 0;
  int bad = 0;

  logic signed [7:0] m_in [N];
  logic signed [7:0] m_wt [N];
  logic signed [7:0] m_bias;

  neuron_feeder #(.N_INPUTS(N), .DATA_W(8), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .bias_we(bias_we), .bias_in(bias_in),
    .start(start), .busy(busy), .done(done),
    .mac_clr(mac_clr), .mac_valid(mac_valid),
    .mac_last(mac_last), .x_out(x_out),
    .w_out(w_out), .bias_out(bias_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] outs();
    return {busy, done, mac_clr, mac_valid, mac_last,
            x_out, w_out, bias_out};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      m_in[i] = 0;
      m_wt[i] = 0;
    end
    m_bias = 0;
  endtask

  task automatic wr(input logic sel, input int addr, input logic [7:0] data);
    cfg_we = 1'b1;
    cfg_sel = sel;
    cfg_addr = 4'(addr);
    cfg_data = data;
    step();
    cfg_we = 1'b0;
    if (addr < N) begin
      if (sel) m_wt[addr] = data;
      else     m_in[addr] = data;
    end
  endtask

  task automatic wr_bias(input logic [7:0] b);
    bias_we = 1'b1;
    bias_in = b;
    step();
    bias_we = 1'b0;
    m_bias = b;
  endtask

  // One evaluation from IDLE; expected waveform derives from the pair list.
  task automatic do_eval(input string tag, input bit inject, output int acc);
    logic signed [7:0] px[$];
    logic signed [7:0] pw[$];
    logic [28:0] exp_v, got;
    int np;
    logic v;
    logic signed [7:0] xe, we;
    acc = 0;
    for (int i = 0; i < N; i++) begin
`ifdef NEURON_FEEDER_SKIP_ZERO_EN
      if (m_wt[i] == 0) continue;
`endif
      px.push_back(m_in[i]);
      pw.push_back(m_wt[i]);
    end
    np = px.size();
    start = 1'b1;
    for (int c = 0; c <= np + D + 2; c++) begin
      step();
      start = 1'b0;
      cfg_we = 1'b0;
      bias_we = 1'b0;
      if (inject && c == 1) begin
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0;
        cfg_data = 8'd99; bias_we = 1'b1; bias_in = 8'd77;
        start = 1'b1;
      end
      if (inject && c == 2) begin
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 4'd1;
        cfg_data = -8'sd7; start = 1'b1;
      end
      v = (c >= 1 && c <= np);
      xe = v ? px[c-1] : 8'sd0;
      we = v ? pw[c-1] : 8'sd0;
      if (v) acc += int'(xe) * int'(we);
      exp_v = {c <= np + D + 1, c == np + D + 1, c == 0,
               v, v && c == np, xe, we, m_bias};
      got = outs();
      total++;
      if (got !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_model();
    total++;
    if (outs() !== 29'd0) begin
      bad++;
      $display("FAIL reset got=%h exp=0", outs());
    end
  endtask

  task automatic test_basic();
    int acc;
    wr(0, 0, 8'd1); wr(0, 1, 8'd2); wr(0, 2, 8'd3);
    wr(1, 0, 8'd4); wr(1, 1, 8'd5); wr(1, 2, 8'd6);
    wr_bias(-8'sd2);
    do_eval("basic", 1'b0, acc);
    total++;
    if (acc !== 32) begin
      bad++;
      $display("FAIL mac_sum got=%0d exp=32", acc);
    end
    total++;
    if (acc + int'($signed(bias_out)) !== 30) begin
      bad++;
      $display("FAIL preact got=%0d exp=30", acc + int'($signed(bias_out)));
    end
  endtask

  task automatic test_busy_write();
    int acc;
    do_eval("busy_wr", 1'b1, acc);
    do_eval("after_busy", 1'b0, acc);
  endtask

  task automatic test_oob_coincident();
    int acc;
    wr(0, 3, 8'd55);
    wr(1, 3, 8'd55);
    do_eval("oob", 1'b0, acc);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd2; cfg_data = -8'sd8;
    m_in[2] = -8'sd8;
    do_eval("coincident", 1'b0, acc);
  endtask

  task automatic test_reset_mid();
    int acc;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    for (int c = 0; c < 4; c++) begin
      total++;
      if (outs() !== 29'd0) begin
        bad++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=0", c, outs());
      end
      step();
    end
    do_eval("post_reset", 1'b0, acc);
  endtask

  task automatic test_back_to_back();
    bit seen;
    wr(0, 0, 8'd1); wr(0, 1, 8'd2); wr(0, 2, 8'd3);
    wr(1, 0, 8'd4); wr(1, 1, 8'd5); wr(1, 2, 8'd6);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1 || c == 8 || c == 9 || c == 10) begin
        total++;
        if ({mac_clr, done, busy} !==
            {c == 1 || c == 10, c == 8, c != 9}) begin
          bad++;
          $display("FAIL b2b cyc=k+%0d got clr/done/busy=%b%b%b",
                   c, mac_clr, done, busy);
        end
      end
    end
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      seen = done;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL b2b_timeout got=no_done exp=done");
    end
    step();
  endtask

`ifdef NEURON_FEEDER_SKIP_ZERO_EN
  task automatic test_skip();
    int acc;
    wr(0, 0, 8'd1); wr(0, 1, 8'd2); wr(0, 2, 8'd3);
    wr(1, 0, 8'd0); wr(1, 1, 8'd5); wr(1, 2, 8'd0);
    do_eval("skip_one", 1'b0, acc);
    wr(1, 1, 8'd0);
    do_eval("skip_all", 1'b0, acc);
  endtask
`endif

  task automatic test_random();
    int acc;
    logic [7:0] d;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        d = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
        wr(1'($urandom), $urandom_range(0, 4), d);
      end
      wr_bias(8'($urandom));
      repeat ($urandom_range(0, 2)) step();
      do_eval("random", 1'b0, acc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_write();
    test_oob_coincident();
    test_reset_mid();
    test_back_to_back();
`ifdef NEURON_FEEDER_SKIP_ZERO_EN
    test_skip();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
